uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//   UART transmitter: serializes one byte per request as an 8N1 frame (start 0, 8 data LSB-first, stop 1).
//   Each bit is held for CLKS_PER_BIT clocks.
//   Sits on the TX pin, opposite the UART receive path. Uses the same state encoding and bit-timing convention.
// PARAMETERS
//   CLKS_PER_BIT  87  clocks per bit (f_clk / baud); legal range 2..65535 (16-bit counter)
// PORTS
//   clk        in   1   system clock, single clock domain, rising edge
//   rst        in   1   asynchronous, active-high reset
//   tx_dv      in   1   request; sampled only in IDLE; tx_byte captured on the same edge
//   tx_byte    in   8   byte to send
//   tx_serial  out  1   serial line; idle high
//   tx_active  out  1   high while a frame is being driven (START..STOP)
//   tx_done    out  1   one-cycle pulse after the stop bit completes
// BEHAVIOUR
//   Reset: state=IDLE, clock count=0, bit index=0, tx_serial=1, tx_active=0, tx_done=0.
//   Reset takes effect immediately and can occur at any point, including mid-frame; the frame is aborted and no tx_done is issued.
//   All outputs are registered. Let N=CLKS_PER_BIT and let E0 be the accept edge (IDLE & tx_dv).
//   IDLE (3'b000): tx_serial=1, tx_done=0. On tx_dv: latch tx_byte, tx_active<=1, tx_serial<=0, count<=0 -> START.
//   START (3'b001): hold 0. When count==N-1: count<=0, bit index<=0, tx_serial<=byte[0] -> DATA. Otherwise count++.
//   DATA (3'b010): hold byte[idx]. When count==N-1: count<=0.
//     If idx<7: idx++, tx_serial<=byte[idx+1].
//     If idx==7: idx<=0, tx_serial<=1 -> STOP.
//   STOP (3'b011): hold 1. When count==N-1: tx_done<=1, tx_active<=0, count<=0 -> CLEANUP.
//   CLEANUP (3'b100): tx_done<=0, tx_serial=1 -> IDLE.
//   Codes 3'b101..3'b111 are unused and return to IDLE with outputs at idle values.
//   Timing relative to E0:
//     start bit on [E0, E0+N)
//     data bit i on [E0+(1+i)N, E0+(2+i)N)
//     stop bit on [E0+9N, E0+10N)
//     tx_done high for exactly one cycle after edge E0+10N
//     earliest next accept edge is E0+10N+2
//   tx_dv is ignored outside IDLE; the captured byte is immune to later tx_byte changes.
//   tx_dv held high continuously gives back-to-back frames at a 10N+2 cycle period.
//   Counter: 16-bit. Compare value is CLKS_PER_BIT-1, truncated to 16 bits. Bit index is 3 bits and never wraps past 7.
// STRUCTURE
//   Shared package uart_pkg:
//     state typedef (IDLE=3'b000, START=3'b001, DATA=3'b010, STOP=3'b011, CLEANUP=3'b100)
//     frame constants DATA_BITS=8, START_LVL=1'b0, STOP_LVL=1'b1, IDLE_LVL=1'b1
//   The same package is shared with the RX side.
//   Sub-module uart_tx_bit_timer:
//     16-bit counter with clear input
//     bit_tick = (count==CLKS_PER_BIT-1), built on Comparator_N_bits #(16)
//   The top level holds the FSM, byte register, bit index and output registers.
// TESTING  (bench uses CLKS_PER_BIT=4 unless noted; sample tx_serial mid-bit)
//   1. Reset: assert rst mid-clock -> tx_serial=1, tx_active=0, tx_done=0 before the next edge; hold 3 cycles, outputs unchanged.
//   2. Single byte: send 0xA5 -> mid-bit samples 0,1,0,1,0,0,1,0,1,1.
//      Check: tx_active high for 40 cycles; tx_done one pulse 40 cycles after accept.
//   3. Busy ignore: during the 0xA5 frame, pulse tx_dv with tx_byte=0xFF at cycle 10
//      -> frame still 0xA5; exactly one tx_done; line idle afterwards.
//   4. Back-to-back: hold tx_dv=1, send 0x00 then 0xFF -> second start-bit falling edge exactly 42 cycles after the first.
//      Check: all 0x00 data bits =0; all 0xFF data bits =1.
//   5. Reset mid-frame: assert rst during data bit 3 of 0x3C -> tx_serial=1 asynchronously; no tx_done.
//      Then send 0x81 -> clean frame 0,1,0,0,0,0,0,0,1,1.
//   6. Minimum divider: CLKS_PER_BIT=2, send 0x55 -> every bit exactly 2 cycles; tx_done at accept+20.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame line levels.
// Used by both the transmit and receive sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    START   = 3'b001,
    DATA    = 3'b010,
    STOP    = 3'b011,
    CLEANUP = 3'b100
  } uart_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Request/line bundle between a byte source and the UART transmitter.
interface uart_tx_serializer_if;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_serial;
  logic       tx_active;
  logic       tx_done;

  modport master (
    output tx_dv,
    output tx_byte,
    input  tx_serial,
    input  tx_active,
    input  tx_done
  );

  modport slave (
    input  tx_dv,
    input  tx_byte,
    output tx_serial,
    output tx_active,
    output tx_done
  );
endinterface

// File: rtl/comparator_n_bits.sv
// Generic N-bit equality comparator.
module Comparator_N_bits #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         eq
);

  assign eq = (a == b);

endmodule

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: 16-bit up-counter with synchronous clear; bit_tick
// marks the last clock of a bit period (count == CLKS_PER_BIT-1).
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  // Compare value truncated to the counter width.
  localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

  logic [15:0] count;

  // Count clocks within the current bit; restart whenever the FSM clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else begin
      count <= count + 16'd1;
    end
  end

  Comparator_N_bits #(.N(16)) u_last_cmp (
    .a  (count),
    .b  (LAST_COUNT),
    .eq (bit_tick)
  );

endmodule

// File: rtl/uart_tx_serializer.sv
// UART 8N1 transmitter. Holds the frame FSM, captured byte, bit index and
// the registered line outputs; bit timing comes from uart_tx_bit_timer.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_tx_serializer_if.slave        bus
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_t state;
  logic [2:0]  bit_idx;
  logic [7:0]  byte_reg;
  logic        serial;
  logic        active;
  logic        done;
  logic        bit_tick;
  logic        timer_clear;

  // Timer runs only while a bit is on the line; held at zero otherwise and
  // restarted at each bit boundary.
  always_comb begin
    timer_clear = 1'b1;
    if (state == START || state == DATA || state == STOP) begin
      timer_clear = bit_tick;
    end else begin
      timer_clear = 1'b1;
    end
  end

  uart_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .bit_tick (bit_tick)
  );

  // Frame sequencer: walks start, data LSB-first, stop, then one cleanup cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_idx  <= 3'd0;
      byte_reg <= 8'd0;
      serial   <= IDLE_LVL;
      active   <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          serial <= IDLE_LVL;
          done   <= 1'b0;
          active <= 1'b0;
          if (bus.tx_dv) begin
            byte_reg <= bus.tx_byte;
            active   <= 1'b1;
            serial   <= START_LVL;
            state    <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            bit_idx <= 3'd0;
            serial  <= byte_reg[0];
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx < LAST_IDX) begin
              bit_idx <= bit_idx + 3'd1;
              serial  <= byte_reg[bit_idx + 3'd1];
            end else begin
              bit_idx <= 3'd0;
              serial  <= STOP_LVL;
              state   <= STOP;
            end
          end
        end
        STOP: begin
          if (bit_tick) begin
            done   <= 1'b1;
            active <= 1'b0;
            state  <= CLEANUP;
          end
        end
        CLEANUP: begin
          done   <= 1'b0;
          serial <= IDLE_LVL;
          state  <= IDLE;
        end
        default: begin
          // Unused encodings recover to idle with the line released.
          bit_idx <= 3'd0;
          serial  <= IDLE_LVL;
          active  <= 1'b0;
          done    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_serial = serial;
  assign bus.tx_active = active;
  assign bus.tx_done   = done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: two instances (4 and 2 clocks
// per bit), table-driven frames, hand-written corner sequences and random
// bytes checked against a frame-level reference model.
module tb_uart_tx_serializer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  uart_tx_serializer_if if4 ();
  uart_tx_serializer_if if2 ();

  uart_tx_serializer #(.CLKS_PER_BIT(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] b;
    logic [9:0] exp;   // line value for frame bit k (0=start .. 9=stop)
    int         n;
    bit         poke;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 8N1 frame as a sequence of ten line levels.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    logic [9:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i + 1] = b[i];
    f[9] = 1'b1;
    return f;
  endfunction

  function automatic logic get_serial(input int n);
    return (n == 2) ? if2.tx_serial : if4.tx_serial;
  endfunction

  function automatic logic get_active(input int n);
    return (n == 2) ? if2.tx_active : if4.tx_active;
  endfunction

  function automatic logic get_done(input int n);
    return (n == 2) ? if2.tx_done : if4.tx_done;
  endfunction

  task automatic set_in(input int n, input logic dv, input logic [7:0] b);
    if (n == 2) begin
      if2.tx_dv   = dv;
      if2.tx_byte = b;
    end else begin
      if4.tx_dv   = dv;
      if4.tx_byte = b;
    end
  endtask

  // Send one byte on an idle DUT and check every cycle of the frame.
  // Call just after a rising edge.
  task automatic send_frame(input logic [7:0] b, input logic [9:0] exp,
                            input int n, input bit poke);
    int cyc;
    set_in(n, 1'b1, b);
    @(posedge clk);              // accept edge E0
    #1;
    set_in(n, 1'b0, b);
    for (int t = 0; t <= 10 * n; t++) begin
      @(negedge clk);
      cyc = t;
      if (t < 10 * n) begin
        chk($sformatf("serial b=%0h n=%0d t=%0d", b, n, cyc), 32'(get_serial(n)), 32'(exp[t / n]));
      end else begin
        chk($sformatf("serial_end b=%0h t=%0d", b, cyc), 32'(get_serial(n)), 32'd1);
      end
      chk($sformatf("active b=%0h t=%0d", b, cyc), 32'(get_active(n)), 32'(t < 10 * n));
      chk($sformatf("done b=%0h t=%0d", b, cyc), 32'(get_done(n)), 32'(t == 10 * n));
      if (poke && t == 10) set_in(n, 1'b1, 8'hFF);
      if (poke && t == 11) set_in(n, 1'b0, b);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_serial", 32'(get_serial(n)), 32'd1);
      chk("idle_active", 32'(get_active(n)), 32'd0);
      chk("idle_done",   32'(get_done(n)),   32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  logic       line[0:127];
  int         fall1;
  int         fall2;
  int         done_cnt;
  logic [7:0] rb;
  int         rn;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    set_in(4, 1'b0, 8'h00);
    set_in(2, 1'b0, 8'h00);

    vecs[0] = '{b: 8'h81, exp: 10'b1100000010, n: 4, poke: 1'b0};
    vecs[1] = '{b: 8'hA5, exp: 10'b1101001010, n: 4, poke: 1'b0};
    vecs[2] = '{b: 8'hA5, exp: 10'b1101001010, n: 4, poke: 1'b1};
    vecs[3] = '{b: 8'h55, exp: 10'b1010101010, n: 2, poke: 1'b0};
    vecs[4] = '{b: 8'hFF, exp: 10'b1111111110, n: 4, poke: 1'b0};
    vecs[5] = '{b: 8'h3C, exp: 10'b1001111000, n: 2, poke: 1'b0};

    // Reset asserted mid-clock: outputs settle before the next edge.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_serial", 32'(if4.tx_serial), 32'd1);
    chk("rst_active", 32'(if4.tx_active), 32'd0);
    chk("rst_done",   32'(if4.tx_done),   32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold_serial", 32'(if4.tx_serial), 32'd1);
      chk("rst_hold_active", 32'(if4.tx_active), 32'd0);
      chk("rst_hold_done",   32'(if4.tx_done),   32'd0);
      chk("rst_hold_serial2", 32'(if2.tx_serial), 32'd1);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back: tx_dv held high, 0x00 then 0xFF.
    set_in(4, 1'b1, 8'h00);
    done_cnt = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      line[c] = if4.tx_serial;
      if (if4.tx_done) done_cnt++;
      if (c == 5)  if4.tx_byte = 8'hFF;
      if (c == 50) if4.tx_dv = 1'b0;
    end
    fall1 = -1;
    fall2 = -1;
    for (int c = 1; c < 120; c++) begin
      if (line[c - 1] === 1'b1 && line[c] === 1'b0) begin
        if (fall1 < 0) fall1 = c;
        else if (fall2 < 0) fall2 = c;
      end
    end
    chk("b2b_fall_found", 32'(fall1 >= 0 && fall2 >= 0), 32'd1);
    chk("b2b_spacing", 32'(fall2 - fall1), 32'd42);
    chk("b2b_done_count", 32'(done_cnt), 32'd2);
    if (fall1 >= 0 && fall2 >= 0 && fall2 + 38 < 120) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("b2b_zero_bit%0d", i), 32'(line[fall1 + (1 + i) * 4 + 2]), 32'd0);
        chk($sformatf("b2b_ones_bit%0d", i), 32'(line[fall2 + (1 + i) * 4 + 2]), 32'd1);
      end
    end
    chk("b2b_idle_after", 32'(line[119]), 32'd1);
    @(posedge clk);
    #1;

    // Reset during data bit 3 of 0x3C: frame aborted, no tx_done.
    set_in(4, 1'b1, 8'h3C);
    @(posedge clk);
    #1 set_in(4, 1'b0, 8'h3C);
    repeat (17) @(posedge clk);
    #2;
    chk("midrst_pre_serial", 32'(if4.tx_serial), 32'd1);
    chk("midrst_pre_active", 32'(if4.tx_active), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_serial", 32'(if4.tx_serial), 32'd1);
    chk("midrst_active", 32'(if4.tx_active), 32'd0);
    chk("midrst_done",   32'(if4.tx_done),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (if4.tx_done || !if4.tx_serial || if4.tx_active) done_cnt++;
    end
    chk("midrst_quiet", 32'(done_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Table of frames (0x81 first, right after the aborted frame).
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].b, vecs[v].exp, vecs[v].n, vecs[v].poke);
    end

    // Random bytes on either divider against the frame model.
    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom);
      rn = ($urandom_range(0, 1) == 0) ? 2 : 4;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_frame(rb, model_frame(rb), rn, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
